stop_watch_bcd_n: RTL and testbench
===================================

// Module: stop_watch_bcd_n
// PURPOSE
//   Parametrised N-digit BCD stopwatch/timer. Counts up or down in cascaded BCD digits.
//   Advances on an internal time-base tick every DVSR clocks.
//   Supports preset load, lap freeze of the display, and a wrap or saturate end-of-range mode.
//   Sits between the time base and the 7-seg display multiplexer.
// PARAMETERS
//   DVSR    5000000  clocks per count increment (>=2)
//   DVSR_W  23       divider width; must satisfy 2**DVSR_W > DVSR
//   DIGITS  3        number of BCD digits (1..8); count range 0 .. 10**DIGITS-1
//   WRAP    1        1: wrap at range end; 0: saturate at range end and set done
// PORTS
//   clk       in   1         system clock, rising edge
//   reset     in   1         asynchronous active-high reset
//   go        in   1         1 = run, 0 = pause (divider and digits hold)
//   clr       in   1         synchronous clear of divider, digits, done, lap freeze
//   up        in   1         1 = count up, 0 = count down
//   load      in   1         synchronous preset of digits from load_val
//   load_val  in   4*DIGITS  preset value, digit k at [4k+3:4k]
//   lap       in   1         lap button (level); rising edge toggles freeze
//   count     out  4*DIGITS  live BCD count, digit 0 = LSD at [3:0]
//   disp      out  4*DIGITS  count, or the captured lap value while frozen
//   tick      out  1         one-cycle pulse when the divider expires
//   wrapped   out  1         one-cycle pulse on a wrap (WRAP=1 only)
//   done      out  1         sticky end-of-range flag (WRAP=0 only)
// BEHAVIOUR
//   Reset: divider=0; all digits=0; done=0; wrapped=0; tick=0; freeze=0; lap_q=0.
//     Reset acts immediately and asynchronously.
//   Priority, each clock edge: clr > load > tick-driven count. go gates only the divider.
//   Divider:
//     go=1: counts 0..DVSR-1, then returns to 0.
//     tick=1 in the cycle where div==DVSR-1 and go=1, so the tick period is DVSR clocks.
//     go=0: div holds and tick=0.
//     clr: div=0.
//   Digit cascade when tick=1, done=0, up=1:
//     d0 increments; dk increments when d0..d(k-1) are all 9.
//     A digit at 9 that increments goes to 0.
//   Digit cascade when tick=1, done=0, up=0:
//     d0 decrements; dk decrements when d0..d(k-1) are all 0.
//     A digit at 0 that decrements goes to 9.
//   End of range:
//     up=1 at all-9s, WRAP=1: all digits go to 0; wrapped=1 for 1 cycle.
//     up=1 at all-9s, WRAP=0: digits hold all-9s; done=1.
//     up=0 at all-0s, WRAP=1: all digits go to 9; wrapped=1 for 1 cycle.
//     up=0 at all-0s, WRAP=0: digits hold 0; done=1.
//     While done=1, ticks are ignored.
//     done clears only on reset, clr or load.
//   up changed mid-run: takes effect on the next tick; the divider is not disturbed.
//   load: digits=load_val, with any nibble >9 clamped to 9; done=0; divider is untouched.
//     load and tick in the same cycle: load wins and that tick is dropped.
//   Lap:
//     lap_q registers lap; a rising edge (lap & ~lap_q) toggles freeze.
//     freeze 0->1: captures the current count into the lap register.
//     freeze=1: disp = lap register; count keeps running.
//     freeze=0: disp = count, combinationally, with no latency.
//     clr: freeze=0.
//   Latency: count changes on the clock edge after the tick is asserted, i.e. tick and the new count are never in the same cycle.
//   All outputs are registered except disp (a mux) and tick (a decode of div).
// TESTING (DVSR=4, DIGITS=3)
//   1. Assert reset mid-run with go=1
//      -> count=000, done=0, disp=000 immediately; holds while reset=1.
//   2. go=1, up=1 from 000 for 40 clocks
//      -> tick every 4th clock; count=010.
//      go=0 for 20 clocks -> count stays 010, tick=0.
//   3. load 099, up=1, one tick -> count=100.
//      load 999, WRAP=1 -> 000 with wrapped=1 for 1 cycle.
//      load 999, WRAP=0 -> stays 999, done=1; further ticks leave 999.
//   4. load 001, up=0 -> 000 after 1 tick.
//      Next tick: WRAP=1 -> 999 with wrapped pulse; WRAP=0 -> stays 000, done=1.
//      Then load 5F3 -> count=593, done=0.
//   5. Lap at count=012: disp freezes at 012 while count reaches 020.
//      Second lap edge -> disp=020 in the same cycle.
//      lap held high for 10 clocks -> only one toggle.
//   6. clr and load together -> count=000, freeze=0, done=0.
//      load coinciding with tick -> count=load_val, no increment.

Source files
------------

// File: rtl/stop_watch_bcd_n.sv
// N-digit BCD stopwatch: up/down cascade on a DVSR-clock time base,
// with preset load, lap freeze and wrap/saturate end-of-range handling.
module stop_watch_bcd_n #(
    parameter int DVSR   = 5000000,
    parameter int DVSR_W = 23,
    parameter int DIGITS = 3,
    parameter int WRAP   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  go,
    input  logic                  clr,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  lap,
    output logic [4*DIGITS-1:0]   count,
    output logic [4*DIGITS-1:0]   disp,
    output logic                  tick,
    output logic                  wrapped,
    output logic                  done
);

    localparam logic [DVSR_W-1:0] DIV_MAX = DVSR_W'(DVSR - 1);

    logic [DVSR_W-1:0]   div;
    logic [4*DIGITS-1:0] count_next;
    logic [4*DIGITS-1:0] load_clamped;
    logic [4*DIGITS-1:0] lap_reg;
    logic                end_range;
    logic                lap_q;
    logic                freeze;

    assign tick = go && (div == DIV_MAX);
    assign disp = freeze ? lap_reg : count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div <= '0;
        end else if (clr) begin
            div <= '0;
        end else if (go) begin
            div <= (div == DIV_MAX) ? '0 : div + DVSR_W'(1);
        end
    end

    always_comb begin
        for (int k = 0; k < DIGITS; k++) begin
            load_clamped[4*k +: 4] = (load_val[4*k +: 4] > 4'd9) ? 4'd9 : load_val[4*k +: 4];
        end
    end

    // Ripple a borrow/carry from the LSD; a carry out of the MSD marks end of range
    always_comb begin
        logic carry;
        logic [3:0] d;
        count_next = count;
        carry = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            d = count[4*k +: 4];
            if (up) begin
                if (carry) count_next[4*k +: 4] = (d == 4'd9) ? 4'd0 : d + 4'd1;
                carry = carry && (d == 4'd9);
            end else begin
                if (carry) count_next[4*k +: 4] = (d == 4'd0) ? 4'd9 : d - 4'd1;
                carry = carry && (d == 4'd0);
            end
        end
        end_range = carry;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count   <= '0;
            done    <= 1'b0;
            wrapped <= 1'b0;
        end else begin
            wrapped <= 1'b0;
            if (clr) begin
                count <= '0;
                done  <= 1'b0;
            end else if (load) begin
                count <= load_clamped;
                done  <= 1'b0;
            end else if (tick && !done) begin
                if (end_range && WRAP == 0) begin
                    done <= 1'b1;
                end else begin
                    count   <= count_next;
                    wrapped <= end_range;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lap_q   <= 1'b0;
            freeze  <= 1'b0;
            lap_reg <= '0;
        end else begin
            lap_q <= lap;
            if (clr) begin
                freeze <= 1'b0;
            end else if (lap && !lap_q) begin
                freeze <= !freeze;
                if (!freeze) lap_reg <= count;
            end
        end
    end

endmodule

// File: tb/tb_stop_watch_bcd_n.sv
// Directed bench: a wrapping and a saturating stopwatch share one
// stimulus stream, DVSR=4, three digits.
module tb_stop_watch_bcd_n;

    logic        clk;
    logic        reset;
    logic        go;
    logic        clr;
    logic        up;
    logic        load;
    logic [11:0] load_val;
    logic        lap;
    logic [11:0] count_w, disp_w, count_s, disp_s;
    logic        tick_w, wrapped_w, done_w;
    logic        tick_s, wrapped_s, done_s;

    int n_checks = 0;
    int n_fail = 0;

    stop_watch_bcd_n #(.DVSR(4), .DVSR_W(3), .DIGITS(3), .WRAP(1)) dut_w (
        .clk(clk), .reset(reset), .go(go), .clr(clr), .up(up),
        .load(load), .load_val(load_val), .lap(lap),
        .count(count_w), .disp(disp_w), .tick(tick_w),
        .wrapped(wrapped_w), .done(done_w)
    );

    stop_watch_bcd_n #(.DVSR(4), .DVSR_W(3), .DIGITS(3), .WRAP(0)) dut_s (
        .clk(clk), .reset(reset), .go(go), .clr(clr), .up(up),
        .load(load), .load_val(load_val), .lap(lap),
        .count(count_s), .disp(disp_s), .tick(tick_s),
        .wrapped(wrapped_s), .done(done_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [11:0] v);
        load = 1'b1;
        load_val = v;
        step(1);
        load = 1'b0;
    endtask

    // Run until one tick is seen, let it land, then pause with div back at 0
    task automatic one_tick();
        int i;
        go = 1'b1;
        #1;
        for (i = 0; i < 10; i++) begin
            if (tick_w) break;
            @(negedge clk);
        end
        if (i == 10) check("tick_timeout", 0, 1);
        check("tick_pair", tick_s, 1);
        @(negedge clk);
        go = 1'b0;
    endtask

    initial begin
        int ticks;
        reset = 1'b1; go = 1'b0; clr = 1'b0; up = 1'b1;
        load = 1'b0; load_val = '0; lap = 1'b0;
        step(2);
        reset = 1'b0;

        // 1. asynchronous reset mid-run
        go = 1'b1;
        step(6);
        check("pre_reset_count", count_w, 12'h001);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("reset_count", count_w, 12'h000);
        check("reset_disp", disp_w, 12'h000);
        check("reset_tick", tick_w, 0);
        check("reset_done", done_s, 0);
        step(3);
        check("reset_hold", count_w, 12'h000);
        reset = 1'b0;
        go = 1'b0;

        // 2. free run 40 clocks, then pause
        go = 1'b1;
        ticks = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (tick_w) ticks++;
            check("tick_pos", tick_w, (i % 4 == 3) ? 1 : 0);
        end
        check("tick_count", ticks, 10);
        check("run_count", count_w, 12'h010);
        go = 1'b0;
        ticks = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tick_w) ticks++;
        end
        check("pause_ticks", ticks, 0);
        check("pause_count", count_w, 12'h010);

        // 3. carry and end of range counting up
        do_load(12'h099);
        check("load_099", count_w, 12'h099);
        one_tick();
        check("carry_100", count_w, 12'h100);
        check("carry_100_s", count_s, 12'h100);
        do_load(12'h999);
        one_tick();
        check("wrap_up_count", count_w, 12'h000);
        check("wrap_up_pulse", wrapped_w, 1);
        check("sat_up_count", count_s, 12'h999);
        check("sat_up_done", done_s, 1);
        check("wrap_no_done", done_w, 0);
        step(1);
        check("wrap_pulse_end", wrapped_w, 0);
        one_tick();
        check("sat_hold", count_s, 12'h999);
        check("sat_hold_done", done_s, 1);
        check("after_wrap", count_w, 12'h001);

        // 4. counting down
        up = 1'b0;
        do_load(12'h001);
        check("load_clears_done", done_s, 0);
        one_tick();
        check("down_000", count_w, 12'h000);
        check("down_000_s", count_s, 12'h000);
        check("down_no_done", done_s, 0);
        one_tick();
        check("wrap_dn_count", count_w, 12'h999);
        check("wrap_dn_pulse", wrapped_w, 1);
        check("sat_dn_count", count_s, 12'h000);
        check("sat_dn_done", done_s, 1);
        do_load(12'h5F3);
        check("clamp_w", count_w, 12'h593);
        check("clamp_s", count_s, 12'h593);
        check("clamp_done", done_s, 0);

        // 5. lap freeze
        up = 1'b1;
        do_load(12'h012);
        lap = 1'b1;
        step(1);
        lap = 1'b0;
        check("lap_capture", disp_w, 12'h012);
        for (int i = 0; i < 8; i++) one_tick();
        check("lap_live", count_w, 12'h020);
        check("lap_frozen", disp_w, 12'h012);
        lap = 1'b1;
        step(1);
        check("lap_release", disp_w, 12'h020);
        go = 1'b1;
        step(9);
        check("lap_held_count", count_w, 12'h022);
        check("lap_held_disp", disp_w, 12'h022);
        go = 1'b0;
        lap = 1'b0;
        step(1);

        // 6. clr vs load, load vs tick
        do_load(12'h999);
        one_tick();
        check("pre_clr_done", done_s, 1);
        lap = 1'b1;
        step(1);
        lap = 1'b0;
        step(1);
        one_tick();
        check("frz_live", count_w, 12'h001);
        check("frz_disp", disp_w, 12'h000);
        check("frz_disp_s", disp_s, 12'h999);
        clr = 1'b1;
        load = 1'b1;
        load_val = 12'h456;
        step(1);
        clr = 1'b0;
        load = 1'b0;
        check("clr_count", count_w, 12'h000);
        check("clr_count_s", count_s, 12'h000);
        check("clr_done", done_s, 0);
        check("clr_unfreeze", disp_s, 12'h000);
        one_tick();
        check("clr_disp_live", disp_w, 12'h001);

        go = 1'b1;
        #1;
        for (int i = 0; i < 10 && !tick_w; i++) @(negedge clk);
        check("tick_seen", tick_w, 1);
        load = 1'b1;
        load_val = 12'h250;
        step(1);
        load = 1'b0;
        go = 1'b0;
        check("load_beats_tick", count_w, 12'h250);
        check("load_beats_tick_s", count_s, 12'h250);
        one_tick();
        check("after_load_tick", count_w, 12'h251);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
